score_ram_arbiter: RTL

Shares the single-port score RAM (16-bit address, 16-bit data, 2-cycle read latency) among several requesters: score updater, scoreboard dump sweep and leaderboard/high-score reader. It uses round-robin arbitration with a req/gnt handshake and issues one RAM access per grant. Read data is returned to the issuing requester, tagged by a per-requester valid pulse. It sits between the game-side controllers and the RAM; no other block drives ram_wren, ram_addr or ram_data.

---
 rtl/score_ram_arbiter_pkg.sv | 19 +
 rtl/score_ram_arbiter_if.sv | 42 ++++
 rtl/score_ram_arbiter_rr_pick.sv | 38 +++
 rtl/score_ram_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/score_ram_arbiter_pkg.sv
// Shared definitions for the score RAM arbiter: default geometry, FSM encoding
// and the fixed requester ids used by the game-side controllers.
package score_ram_pkg;

  localparam int NREQ_DEF   = 3;
  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int REQ_UPDATE     = 0;
  localparam int REQ_SCOREBOARD = 1;
  localparam int REQ_LEADER     = 2;

endpackage

// File: rtl/score_ram_arbiter_if.sv
// Requester and RAM-side bus of the score RAM arbiter.
// SCORE_ARB_LOCK_EN adds the per-requester lock vector.
interface score_ram_arbiter_if import score_ram_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               ram_wren;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic [DW-1:0]      ram_q;
`ifdef SCORE_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;

  modport slave (
    input  req, we, addr, wdata, ram_q, lock,
    output gnt, rvalid, rdata, ram_wren, ram_addr, ram_data
  );
  modport master (
    output req, we, addr, wdata, ram_q, lock,
    input  gnt, rvalid, rdata, ram_wren, ram_addr, ram_data
  );
`else
  modport slave (
    input  req, we, addr, wdata, ram_q,
    output gnt, rvalid, rdata, ram_wren, ram_addr, ram_data
  );
  modport master (
    output req, we, addr, wdata, ram_q,
    input  gnt, rvalid, rdata, ram_wren, ram_addr, ram_data
  );
`endif

endinterface

// File: rtl/score_ram_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_win,
  output logic                    o_valid
);

  localparam int PW = $clog2(NREQ);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] NREQ_W = SW'(NREQ);

  logic [SW-1:0] w_sum;
  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic          w_found;

  // Walk the requesters in priority order starting at the pointer
  always_comb begin
    o_win   = {NREQ{1'b0}};
    w_found = 1'b0;
    w_sum   = {SW{1'b0}};
    w_idx   = {PW{1'b0}};
    w_hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum        = {1'b0, i_ptr} + SW'(i);
      w_idx        = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : PW'(w_sum);
      w_hit        = ~w_found & i_req[w_idx];
      o_win[w_idx] = o_win[w_idx] | w_hit;
      w_found      = w_found | w_hit;
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/score_ram_arbiter.sv
// Round-robin arbiter sharing the single-port score RAM; one access per grant,
// read data returned with a per-requester valid pulse. Option: SCORE_ARB_LOCK_EN.
module score_ram_arbiter import score_ram_pkg::*; #(
  parameter int NREQ   = NREQ_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  score_ram_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t                  r_state, w_state_nxt;
  logic [NREQ-1:0]             r_gnt, w_gnt_nxt;
  logic                        r_ram_wren, w_wren_nxt;
  logic [AW-1:0]               r_ram_addr, w_addr_nxt;
  logic [DW-1:0]               r_ram_data, w_data_nxt;
  logic [PW-1:0]               r_ptr, w_ptr_nxt;
  logic [PW-1:0]               r_win, w_win_nxt;
  logic [PW-1:0]               w_win_inc;
  logic [RD_LAT-1:0]           r_tag_vld;
  logic [RD_LAT-1:0][PW-1:0]   r_tag_id;
  logic [NREQ-1:0]             r_rvalid;
  logic [DW-1:0]               r_rdata;

  logic [NREQ-1:0]             w_pick_win;
  logic                        w_pick_vld;
  logic [PW-1:0]               w_pick_idx;
  logic [PW-1:0]               w_sel;
  logic                        w_any;
  logic                        w_lock_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_win   (w_pick_win),
    .o_valid (w_pick_vld)
  );

  // Binary index of the round-robin winner
  always_comb begin
    w_pick_idx = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_pick_idx = w_pick_idx | (w_pick_win[i] ? PW'(i) : {PW{1'b0}});
    end
  end

`ifdef SCORE_ARB_LOCK_EN
  logic r_hold, w_hold_nxt;
  logic r_win_vld, w_win_vld_nxt;

  // A locked last winner keeps the bus without moving the pointer
  assign w_lock_hit = r_win_vld & bus.lock[r_win] & bus.req[r_win];
`else
  assign w_lock_hit = 1'b0;
`endif

  assign w_sel     = w_lock_hit ? r_win : w_pick_idx;
  assign w_any     = w_lock_hit | w_pick_vld;
  assign w_win_inc = (r_win == PW'(NREQ - 1)) ? {PW{1'b0}} : r_win + PW'(1'b1);

  // Next-state and next-output logic; RAM bus is zero outside GRANT
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = {NREQ{1'b0}};
    w_wren_nxt  = 1'b0;
    w_addr_nxt  = {AW{1'b0}};
    w_data_nxt  = {DW{1'b0}};
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
`ifdef SCORE_ARB_LOCK_EN
    w_hold_nxt    = r_hold;
    w_win_vld_nxt = r_win_vld;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = ONE_HOT0 << w_sel;
          w_wren_nxt  = bus.we[w_sel];
          w_addr_nxt  = bus.addr[int'(w_sel)*AW +: AW];
          w_data_nxt  = bus.we[w_sel] ? bus.wdata[int'(w_sel)*DW +: DW] : {DW{1'b0}};
          w_win_nxt   = w_sel;
`ifdef SCORE_ARB_LOCK_EN
          w_hold_nxt    = w_lock_hit;
          w_win_vld_nxt = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_IDLE;
`ifdef SCORE_ARB_LOCK_EN
        w_ptr_nxt   = r_hold ? r_ptr : w_win_inc;
`else
        w_ptr_nxt   = w_win_inc;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered RAM/grant outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= {NREQ{1'b0}};
      r_ram_wren <= 1'b0;
      r_ram_addr <= {AW{1'b0}};
      r_ram_data <= {DW{1'b0}};
      r_ptr      <= {PW{1'b0}};
      r_win      <= {PW{1'b0}};
`ifdef SCORE_ARB_LOCK_EN
      r_hold     <= 1'b0;
      r_win_vld  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ram_wren <= w_wren_nxt;
      r_ram_addr <= w_addr_nxt;
      r_ram_data <= w_data_nxt;
      r_ptr      <= w_ptr_nxt;
      r_win      <= w_win_nxt;
`ifdef SCORE_ARB_LOCK_EN
      r_hold     <= w_hold_nxt;
      r_win_vld  <= w_win_vld_nxt;
`endif
    end
  end

  // Read-tag pipeline tracks each read to its q cycle, then returns it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag_vld <= {RD_LAT{1'b0}};
      r_tag_id  <= '0;
      r_rvalid  <= {NREQ{1'b0}};
      r_rdata   <= {DW{1'b0}};
    end else begin
      r_tag_vld[0] <= (r_state == ST_GRANT) & ~r_ram_wren;
      r_tag_id[0]  <= r_win;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      r_rvalid <= r_tag_vld[RD_LAT-1] ? (ONE_HOT0 << r_tag_id[RD_LAT-1]) : {NREQ{1'b0}};
      r_rdata  <= r_tag_vld[RD_LAT-1] ? bus.ram_q : r_rdata;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.ram_wren = r_ram_wren;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_data = r_ram_data;

endmodule
